div_frontend: RTL and testbench

//  Sequencing stage that sits directly upstream of the unsigned divider core and

---
 rtl/div_frontend_pkg.sv | 33 +++
 rtl/div_sign_fix.sv | 32 +++
 rtl/div_frontend.sv | 141 ++++++++++++++
 tb/tb_div_frontend.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_frontend_pkg.sv
// Shared types and constants for the divider front-end and its helpers.
package div_frontend_pkg;

  localparam int unsigned DEF_XLEN     = 32;
  localparam int unsigned DEF_TAG_W    = 5;
  localparam int unsigned DEF_CORE_LAT = 40;

  // ctrl is funct3[1:0]
  localparam int unsigned CTRL_W   = 2;
  localparam int unsigned CTRL_REM = 1;
  localparam int unsigned CTRL_UNS = 0;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Per-operation info kept while the core is busy
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              sign_a;
    logic              sign_b;
  } op_t;

endpackage

// File: rtl/div_sign_fix.sv
// Applies RV32M result signs to an unsigned quotient/remainder pair.
module div_sign_fix
  import div_frontend_pkg::*;
#(
  parameter int unsigned XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0]   quotient,
  input  logic [XLEN-1:0]   remainder,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [XLEN-1:0]   result_c
);

  logic is_signed_c;
  logic neg_q_c;
  logic neg_r_c;

  // Quotient takes the xor of signs, remainder follows the dividend
  always_comb begin
    is_signed_c = !ctrl[CTRL_UNS];
    neg_q_c     = is_signed_c && (sign_a ^ sign_b);
    neg_r_c     = is_signed_c && sign_a;
    result_c    = '0;
    if (ctrl[CTRL_REM]) begin
      result_c = neg_r_c ? (~remainder + XLEN'(1)) : remainder;
    end else begin
      result_c = neg_q_c ? (~quotient + XLEN'(1)) : quotient;
    end
  end

endmodule

// File: rtl/div_frontend.sv
// Sequencer in front of the unsigned divider core: handles RV32M special
// cases locally, launches the core otherwise, and holds the signed result.
module div_frontend
  import div_frontend_pkg::*;
#(
  parameter int unsigned XLEN     = DEF_XLEN,
  parameter int unsigned TAG_W    = DEF_TAG_W,
  parameter int unsigned CORE_LAT = DEF_CORE_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CTRL_W-1:0] req_ctrl,
  input  logic [XLEN-1:0]   req_dividend,
  input  logic [XLEN-1:0]   req_divisor,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              core_start,
  output logic [XLEN-1:0]   core_dividend,
  output logic [XLEN-1:0]   core_divisor,
  input  logic              core_done,
  input  logic [XLEN-1:0]   core_quotient,
  input  logic [XLEN-1:0]   core_remainder,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [TAG_W-1:0]  resp_tag
);

  localparam int unsigned CNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT + 1) : 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e           state;
  logic [CNT_W-1:0] flush_cnt;
  op_t              op;

  logic             req_signed_c;
  logic             sign_a_c;
  logic             sign_b_c;
  logic [XLEN-1:0]  mag_a_c;
  logic [XLEN-1:0]  mag_b_c;
  logic             div_zero_c;
  logic             overflow_c;
  logic [XLEN-1:0]  fix_result_c;

  // Decode the incoming request: operand signs, magnitudes, special cases
  always_comb begin
    req_signed_c = !req_ctrl[CTRL_UNS];
    sign_a_c     = req_signed_c && req_dividend[XLEN-1];
    sign_b_c     = req_signed_c && req_divisor[XLEN-1];
    mag_a_c      = sign_a_c ? (~req_dividend + XLEN'(1)) : req_dividend;
    mag_b_c      = sign_b_c ? (~req_divisor + XLEN'(1)) : req_divisor;
    div_zero_c   = (req_divisor == '0);
    overflow_c   = req_signed_c && (req_dividend == INT_MIN) && (req_divisor == '1);
  end

  div_sign_fix #(
    .XLEN (XLEN)
  ) u_sign_fix (
    .quotient  (core_quotient),
    .remainder (core_remainder),
    .sign_a    (op.sign_a),
    .sign_b    (op.sign_b),
    .ctrl      (op.ctrl),
    .result_c  (fix_result_c)
  );

  // Control FSM with registered handshake and core outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_FLUSH;
      flush_cnt     <= CNT_W'(CORE_LAT);
      op            <= '0;
      req_ready     <= 1'b0;
      core_start    <= 1'b0;
      core_dividend <= '0;
      core_divisor  <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_tag      <= '0;
    end else begin
      core_start <= 1'b0;
      case (state)
        // The core has no reset: wait out any operation it may still be running
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            op        <= '{ctrl: req_ctrl, sign_a: sign_a_c, sign_b: sign_b_c};
            resp_tag  <= req_tag;
            if (div_zero_c) begin
              resp_data  <= req_ctrl[CTRL_REM] ? req_dividend : '1;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else if (overflow_c) begin
              resp_data  <= req_ctrl[CTRL_REM] ? '0 : INT_MIN;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else begin
              core_dividend <= mag_a_c;
              core_divisor  <= mag_b_c;
              core_start    <= 1'b1;
              state         <= ST_START;
            end
          end
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            resp_data  <= fix_result_c;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_FLUSH;
          flush_cnt  <= CNT_W'(CORE_LAT);
          req_ready  <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_frontend.sv
// Self-checking bench for div_frontend with a behavioural divider core.
module tb_div_frontend;

  localparam int CORE_LAT = 40;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_ctrl;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic [4:0]  req_tag;
  logic        core_start;
  logic [31:0] core_dividend;
  logic [31:0] core_divisor;
  logic        core_done;
  logic [31:0] core_quotient;
  logic [31:0] core_remainder;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;

  div_frontend #(
    .XLEN     (32),
    .TAG_W    (5),
    .CORE_LAT (CORE_LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_ctrl       (req_ctrl),
    .req_dividend   (req_dividend),
    .req_divisor    (req_divisor),
    .req_tag        (req_tag),
    .core_start     (core_start),
    .core_dividend  (core_dividend),
    .core_divisor   (core_divisor),
    .core_done      (core_done),
    .core_quotient  (core_quotient),
    .core_remainder (core_remainder),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_tag       (resp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count launch pulses seen by the core
  always @(posedge clk) begin
    if (core_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  // RV32M result from the instruction definition
  function automatic logic [31:0] ref_result(input logic [1:0] ctrl, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return ctrl[1] ? a : 32'hFFFF_FFFF;
    if (!ctrl[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return ctrl[1] ? 32'h0 : 32'h8000_0000;
      return ctrl[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return ctrl[1] ? (a % b) : (a / b);
  endfunction

  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
    logic signed [31:0] sx;
    sx = x;
    if (is_signed && sx < 0) return 32'(-sx);
    return x;
  endfunction

  // One full transaction; the bench plays the divider core with latency lat
  task automatic run_op(input logic [1:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int lat, input int bp);
    logic [31:0] exp;
    logic [31:0] ma;
    logic [31:0] mb;
    logic        special;
    int          n;
    int          starts0;
    exp     = ref_result(ctrl, a, b);
    special = (b == 32'h0) || (!ctrl[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    ma      = magnitude(a, !ctrl[0]);
    mb      = magnitude(b, !ctrl[0]);
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      $display("FAIL ready_timeout got=%b exp=1", req_ready);
      bad++;
      return;
    end
    starts0      = start_cnt;
    req_valid    = 1'b1;
    req_ctrl     = ctrl;
    req_dividend = a;
    req_divisor  = b;
    req_tag      = tag;
    @(negedge clk);
    req_valid    = 1'b0;
    req_dividend = 32'($urandom);
    req_divisor  = 32'($urandom);
    if (special) begin
      total++;
      if (resp_valid !== 1'b1) begin
        $display("FAIL special_latency got=%b exp=1", resp_valid);
        bad++;
      end
    end else begin
      total++;
      if (core_start !== 1'b1) begin
        $display("FAIL start_latency got=%b exp=1", core_start);
        bad++;
      end
      total++;
      if (core_dividend !== ma || core_divisor !== mb) begin
        $display("FAIL core_operands got=%h/%h exp=%h/%h", core_dividend, core_divisor, ma, mb);
        bad++;
      end
      @(negedge clk);
      total++;
      if (core_start !== 1'b0) begin
        $display("FAIL start_width got=%b exp=0", core_start);
        bad++;
      end
      repeat (lat - 1) @(negedge clk);
      total++;
      if (core_dividend !== ma || core_divisor !== mb) begin
        $display("FAIL core_operands_stable got=%h/%h exp=%h/%h", core_dividend, core_divisor, ma, mb);
        bad++;
      end
      core_quotient  = ma / mb;
      core_remainder = ma % mb;
      core_done      = 1'b1;
      @(negedge clk);
      core_done      = 1'b0;
      core_quotient  = 32'($urandom);
      core_remainder = 32'($urandom);
      total++;
      if (resp_valid !== 1'b1) begin
        $display("FAIL result_latency got=%b exp=1", resp_valid);
        bad++;
      end
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || resp_data !== exp || resp_tag !== tag || req_ready !== 1'b0) begin
        $display("FAIL hold cyc=%0d got v=%b d=%h t=%h rdy=%b exp v=1 d=%h t=%h rdy=0",
                 i, resp_valid, resp_data, resp_tag, req_ready, exp, tag);
        bad++;
      end
    end
    total++;
    if (resp_data !== exp || resp_tag !== tag || req_ready !== 1'b0) begin
      $display("FAIL result ctrl=%b a=%h b=%h got d=%h t=%h rdy=%b exp d=%h t=%h rdy=0",
               ctrl, a, b, resp_data, resp_tag, req_ready, exp, tag);
      bad++;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL release got v=%b rdy=%b exp v=0 rdy=1", resp_valid, req_ready);
      bad++;
    end
    total++;
    if ((start_cnt - starts0) !== (special ? 0 : 1)) begin
      $display("FAIL start_count got=%0d exp=%0d", start_cnt - starts0, special ? 0 : 1);
      bad++;
    end
  endtask

  // Wait out the post-reset flush, checking no response appears
  task automatic wait_flush(input int inject_at);
    int k;
    logic saw_resp;
    k = 0;
    saw_resp = 1'b0;
    while (req_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
      if (resp_valid !== 1'b0) saw_resp = 1'b1;
      if (k == inject_at) begin
        core_done      = 1'b1;
        core_quotient  = 32'h1234_5678;
        core_remainder = 32'h9ABC_DEF0;
      end else begin
        core_done = 1'b0;
      end
    end
    core_done = 1'b0;
    total++;
    if (saw_resp) begin
      $display("FAIL flush_no_resp got=1 exp=0");
      bad++;
    end
    total++;
    if (k < CORE_LAT || k > CORE_LAT + 1) begin
      $display("FAIL flush_length got=%0d exp=%0d..%0d", k, CORE_LAT, CORE_LAT + 1);
      bad++;
    end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL after_flush got v=%b rdy=%b exp v=0 rdy=1", resp_valid, req_ready);
      bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (req_ready !== 1'b0 || core_start !== 1'b0 || resp_valid !== 1'b0) begin
      $display("FAIL reset_flags got rdy=%b st=%b v=%b exp 0 0 0", req_ready, core_start, resp_valid);
      bad++;
    end
    total++;
    if (core_dividend !== 32'h0 || core_divisor !== 32'h0 || resp_data !== 32'h0 || resp_tag !== 5'h0) begin
      $display("FAIL reset_data got %h %h %h %h exp 0", core_dividend, core_divisor, resp_data, resp_tag);
      bad++;
    end
    rst = 1'b0;
    wait_flush(3);
  endtask

  task automatic test_signed();
    run_op(2'b00, 32'hFFFF_FFF9, 32'h2, 5'd3, 5, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h2, 5'd4, 1, 0);
    run_op(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd5, 7, 1);
    run_op(2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd6, CORE_LAT, 0);
  endtask

  task automatic test_unsigned();
    run_op(2'b01, 32'hFFFF_FFF9, 32'h2, 5'd7, 3, 0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'h2, 5'd8, 2, 0);
  endtask

  task automatic test_div_zero();
    run_op(2'b00, 32'd5, 32'h0, 5'd9, 1, 0);
    run_op(2'b10, 32'd5, 32'h0, 5'd10, 1, 0);
    run_op(2'b01, 32'hDEAD_BEEF, 32'h0, 5'd11, 1, 1);
    run_op(2'b11, 32'h8000_0000, 32'h0, 5'd12, 1, 0);
  endtask

  task automatic test_overflow();
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1, 0);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 4, 0);
    run_op(2'b00, 32'h8000_0000, 32'h1, 5'd16, 2, 0);
  endtask

  task automatic test_backpressure();
    run_op(2'b00, 32'd1000, 32'd7, 5'd17, 6, 10);
    run_op(2'b10, 32'd1000, 32'h0, 5'd18, 1, 10);
    run_op(2'b11, 32'd1000, 32'd7, 5'd19, 2, 0);
  endtask

  task automatic test_reset_mid_op();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    req_valid    = 1'b1;
    req_ctrl     = 2'b01;
    req_dividend = 32'd100;
    req_divisor  = 32'd7;
    req_tag      = 5'd20;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0 || core_start !== 1'b0) begin
      $display("FAIL mid_reset got v=%b rdy=%b st=%b exp 0 0 0", resp_valid, req_ready, core_start);
      bad++;
    end
    wait_flush(5);
    run_op(2'b00, 32'hFFFF_FF00, 32'd16, 5'd21, 3, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 50));
        2:       a = 32'h0 - 32'($urandom_range(1, 50));
        default: a = 32'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        3:       b = 32'h0 - 32'($urandom_range(1, 20));
        default: b = 32'($urandom);
      endcase
      run_op(2'($urandom), a, b, 5'($urandom), int'($urandom_range(1, CORE_LAT)),
             int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_ctrl       = 2'b00;
    req_dividend   = 32'h0;
    req_divisor    = 32'h0;
    req_tag        = 5'h0;
    core_done      = 1'b0;
    core_quotient  = 32'h0;
    core_remainder = 32'h0;
    resp_ready     = 1'b0;
    test_reset();
    test_signed();
    test_unsigned();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
